// File: rtl/tick_gen.sv
// Programmable tick prescaler with burst/continuous modes and start/stop control.
// Define TICK_GEN_DIV_LATCH_EN to latch div_i on start instead of tracking it live.
module tick_gen #(
  parameter int Width      = 8,
  parameter int BurstWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [Width-1:0]      div_i,
  input  logic [BurstWidth-1:0] burst_i,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [Width-1:0]      presc;
  logic [BurstWidth-1:0] count;
  logic [BurstWidth-1:0] count_nxt;
  logic [BurstWidth-1:0] burst_q;
  logic [Width-1:0]      div_eff;
  logic                  hit;
  logic                  last;

`ifdef TICK_GEN_DIV_LATCH_EN
  logic [Width-1:0] div_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else if (state == IDLE && start_i && !stop_i) begin
      div_q <= div_i;
    end
  end

  assign div_eff = div_q;
`else
  assign div_eff = div_i;
`endif

  // >= so a divisor lowered below the prescaler ticks on the next edge
  assign hit       = (presc >= div_eff);
  assign count_nxt = count + 1'b1;
  assign last      = (burst_q != '0) && (count_nxt == burst_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      presc   <= '0;
      count   <= '0;
      burst_q <= '0;
      tick_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            state   <= RUN;
            presc   <= '0;
            count   <= '0;
            burst_q <= burst_i;
          end
        end
        RUN: begin
          if (stop_i) begin
            state <= IDLE;
            presc <= '0;
          end else if (hit) begin
            tick_o <= 1'b1;
            presc  <= '0;
            count  <= count_nxt;
            if (last) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state == RUN);

endmodule
